multicycle_ctrl: RTL



---
 rtl/mc_pkg.sv | 61 ++++++
 rtl/mc_ctrl_decode.sv | 74 +++++++
 rtl/multicycle_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle control FSM and its decoder.
package mc_pkg;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR,
        MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, TRAP, HALT
    } mcState_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef struct packed {
        logic       selectIns;
        logic       regWrite;
        logic       regDst;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic       memWrite;
        logic       memtoReg;
        logic       beq;
        logic [1:0] pcSrc;
        logic       pcWrite;
        logic       irWrite;
        logic [1:0] aluOp;
        logic       instrDone;
        logic       illegalOp;
        logic       halted;
    } ctrlWord_t;

    // Dispatch from DECODE; undefined opcodes trap.
    function automatic mcState_t decodeOpcode(input logic [5:0] op);
        case (op)
            OP_R:         return EXEC_R;
            OP_ADDI:      return EXEC_I;
            OP_LW, OP_SW: return MEM_ADDR;
            OP_BEQ:       return BRANCH;
            OP_J:         return JUMP;
            OP_HALT:      return HALT;
            default:      return TRAP;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state -> datapath control word. Moore except the FETCH writes,
// the MEM_WR completion pulse and the HALT entry pulse.
module mc_ctrl_decode
    import mc_pkg::*;
(
    input  mcState_t  state,
    input  logic      memReady,
    input  logic      haltEntry,
    output ctrlWord_t ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                ctrl.aluSrcB = SRCB_FOUR;
                ctrl.pcSrc   = PCSRC_ALU;
                ctrl.aluOp   = ALUOP_ADD;
                ctrl.irWrite = memReady;
                ctrl.pcWrite = memReady;
            end
            DECODE:   ctrl.aluSrcB = SRCB_IMM_SH2;
            EXEC_R: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_RT;
                ctrl.aluOp   = ALUOP_FUNCT;
            end
            WB_R: begin
                ctrl.regDst    = 1'b1;
                ctrl.regWrite  = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            EXEC_I, MEM_ADDR: begin
                ctrl.aluSrcA = 1'b1;
                ctrl.aluSrcB = SRCB_IMM;
            end
            WB_I: begin
                ctrl.regWrite  = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            MEM_RD:   ctrl.selectIns = 1'b1;
            MEM_WB: begin
                ctrl.regWrite  = 1'b1;
                ctrl.memtoReg  = 1'b1;
                ctrl.instrDone = 1'b1;
            end
            MEM_WR: begin
                ctrl.selectIns = 1'b1;
                ctrl.memWrite  = 1'b1;
                ctrl.instrDone = memReady;
            end
            BRANCH: begin
                ctrl.aluSrcA   = 1'b1;
                ctrl.aluSrcB   = SRCB_RT;
                ctrl.aluOp     = ALUOP_SUB;
                ctrl.beq       = 1'b1;
                ctrl.pcSrc     = PCSRC_ALUOUT;
                ctrl.instrDone = 1'b1;
            end
            JUMP: begin
                ctrl.pcWrite   = 1'b1;
                ctrl.pcSrc     = PCSRC_JUMP;
                ctrl.instrDone = 1'b1;
            end
            TRAP:     ctrl.illegalOp = 1'b1;
            HALT: begin
                ctrl.halted    = 1'b1;
                ctrl.instrDone = haltEntry;
            end
            default:  ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM: state register, next-state logic and the
// retired-instruction counter; control word comes from mc_ctrl_decode.
module multicycle_ctrl
    import mc_pkg::*;
#(
    parameter int OPW    = 6,
    parameter int ALUOPW = 2,
    parameter int CNTW   = 16,
    parameter int MEM_HS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic [OPW-1:0]    opcode,
    input  logic              mem_ready,
    output logic              SelectIns,
    output logic              RegWrite,
    output logic              RegDst,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic              MemWrite,
    output logic              MemtoReg,
    output logic              BEQ,
    output logic [1:0]        PCSrc,
    output logic              PCWrite,
    output logic              IRWrite,
    output logic [ALUOPW-1:0] ALUOp,
    output logic              instr_done,
    output logic              illegal_op,
    output logic              halted,
    output logic [CNTW-1:0]   instr_count,
    output mcState_t          dbgState
);

    // mem_ready is sampled only in FETCH, MEM_RD and MEM_WR: the access
    // completes in the cycle mem_ready is high, otherwise the state repeats.
    logic      memReady;
    mcState_t  state, nextState;
    logic      wasHalt;
    ctrlWord_t ctrl;
    logic [CNTW-1:0] instrCount;

    assign memReady = (MEM_HS != 0) ? mem_ready : 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wasHalt    <= 1'b0;
            instrCount <= '0;
        end else begin
            state   <= nextState;
            wasHalt <= (state == HALT);
            if (ctrl.instrDone)
                instrCount <= instrCount + CNTW'(1);
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:     if (run) nextState = FETCH;
            FETCH:    if (memReady) nextState = DECODE;
            DECODE:   nextState = decodeOpcode(6'(opcode));
            EXEC_R:   nextState = WB_R;
            EXEC_I:   nextState = WB_I;
            MEM_ADDR: nextState = (6'(opcode) == OP_SW) ? MEM_WR : MEM_RD;
            MEM_RD:   if (memReady) nextState = MEM_WB;
            MEM_WR:   if (memReady) nextState = FETCH;
            WB_R, WB_I, MEM_WB, BRANCH, JUMP, TRAP: nextState = FETCH;
            HALT:     nextState = HALT;
            default:  nextState = IDLE;
        endcase
    end

    mc_ctrl_decode uDecode (
        .state     (state),
        .memReady  (memReady),
        .haltEntry (!wasHalt),
        .ctrl      (ctrl)
    );

    assign SelectIns   = ctrl.selectIns;
    assign RegWrite    = ctrl.regWrite;
    assign RegDst      = ctrl.regDst;
    assign ALUSrcA     = ctrl.aluSrcA;
    assign ALUSrcB     = ctrl.aluSrcB;
    assign MemWrite    = ctrl.memWrite;
    assign MemtoReg    = ctrl.memtoReg;
    assign BEQ         = ctrl.beq;
    assign PCSrc       = ctrl.pcSrc;
    assign PCWrite     = ctrl.pcWrite;
    assign IRWrite     = ctrl.irWrite;
    assign ALUOp       = ALUOPW'(ctrl.aluOp);
    assign instr_done  = ctrl.instrDone;
    assign illegal_op  = ctrl.illegalOp;
    assign halted      = ctrl.halted;
    assign instr_count = instrCount;
    assign dbgState    = state;

endmodule
